milano_csr_file: RTL
====================

Name: milano_csr_file

Overview:
Machine-mode CSR register file for the milano RV32IM core. It is the responder for two initiators:
- the trap controller, which walks WR_MCAUSE/WR_MEPC/WR_MTVAL/WR_MSTATUS and drives one write per cycle;
- execute-stage Zicsr instructions, which use the csr_opt_e operations.

It also holds the 64-bit cycle and instret counters and drives mtvec, mepc and the global interrupt enable back to the fetch and trap logic.

Parameters:
HART_ID, 32'h0, value returned by mhartid
MTVEC_RESET, 32'h0000_0000, reset value of mtvec (direct mode)
MISA_VALUE, 32'h4000_1100, constant misa (MXL=1, I, M)

Ports:
clk_i  in  1  core clock
rst_i  in  1  synchronous, active-high reset
csr_en_i  in  1  execute stage issues a CSR instruction this cycle
csr_op_i  in  4  csr_opt_e operation
csr_addr_i  in  12  csr_num_e address
csr_wdata_i  in  32  rs1 value, or zimm zero-extended for *I forms
csr_rdata_o  out  32  old CSR value, combinational
csr_illegal_o  out  1  illegal CSR access, combinational
trap_wr_en_i  in  1  trap controller write strobe
trap_wr_sel_i  in  4  csr_ctrl_state_e target
trap_wr_data_i  in  32  data for mcause/mepc/mtval; ignored for mstatus
trap_wr_ack_o  out  1  registered acknowledge
mret_i  in  1  MRET retiring this cycle
instr_retire_i  in  1  one instruction retired this cycle
mtvec_o  out  32  trap vector base
mepc_o  out  32  return address
mstatus_mie_o  out  1  global interrupt enable

Behaviour:
- Reset state (clk edge with rst_i=1):
  - mstatus MIE=0, MPIE=0 (MPP is fixed 2'b11, so mstatus reads 32'h0000_1800)
  - mtvec=MTVEC_RESET
  - mie, mscratch, mepc, mcause, mtval = 0
  - mcycle, minstret (64-bit) = 0
  - trap_wr_ack_o=0
  - rst_i overrides every concurrent write, increment and mret.
- Reads are combinational from csr_addr_i whenever csr_en_i=1; csr_rdata_o=0 when csr_en_i=0.
- Write value by operation:
  - RW/RWI: wdata
  - RS/RSI: old | wdata
  - RC/RCI: old & ~wdata
  - NONE: no write, not illegal
- Write-enable:
  - RW/RWI always write.
  - RS/RC/RSI/RCI write only when wdata != 0; otherwise it is a read-only access.
  - Writes commit at the next clock edge.
- csr_illegal_o=1 when csr_en_i=1 and either:
  - the address is not in csr_num_e, or
  - the access writes (per the write-enable rule) to MHARTID.
  An illegal access changes no state.
- Implemented bits:
  - mstatus: only MIE[3] and MPIE[7] are writable.
  - mie: bits 3, 7, 11 writable; other bits read 0.
  - mip: reads 0, writes ignored.
  - misa: reads MISA_VALUE, writes ignored and not illegal.
  - mtvec, mepc: bits[1:0] forced 0.
  - mcause, mtval, mscratch: full 32 bits.
- Counters:
  - mcycle+1 every cycle.
  - minstret+1 when instr_retire_i=1.
  - Carry propagates from bit 31 into the high half; all-ones wraps to 0.
  - A CSR write to MCYCLE/MCYCLEH/MINSTRET/MINSTRETH replaces that half and suppresses that counter's increment in the same cycle.
- Trap write port:
  - Each cycle with trap_wr_en_i=1 is one write, committed at the edge.
  - trap_wr_ack_o=1 for exactly the following cycle.
  - Back-to-back writes give back-to-back acks.
  - Targets:
    - WR_MCAUSE/WR_MEPC/WR_MTVAL: load trap_wr_data_i (mepc with bits[1:0] cleared).
    - WR_MSTATUS: MPIE<=MIE, MIE<=0.
    - WR_IDLE: no write, but still acked.
- mret_i: MIE<=MPIE, MPIE<=1.
- Collision priority, same cycle: rst_i > trap write > mret_i > CSR instruction write.
  - The losing CSR instruction write to the same register is dropped.
  - Writes to different registers both commit.
- mtvec_o, mepc_o and mstatus_mie_o are the registered values; an update is visible the cycle after the edge.

Decomposition:
- Already present in milano_pkg: csr_opt_e, csr_num_e, csr_ctrl_state_e.
- Add to milano_pkg:
  - mstatus bit-index localparams (MIE=3, MPIE=7, MPP=12:11);
  - MIE_MASK = 32'h0000_0888.
- One sub-module, milano_csr_counter64: 64-bit counter with increment enable, per-half load enables and load data. Instantiated twice (cycle, instret).

Test Plan:
- Reset, then read MSTATUS, MISA, MHARTID (HART_ID=5) -> 32'h1800, 32'h4000_1100, 32'h5; csr_illegal_o=0.
- RW MSCRATCH 32'hDEAD_BEEF, RS 32'h0000_00F0, RC 32'hDEAD_0000 -> reads return 0, then 32'hDEAD_BEEF, then 32'hDEAD_BEFF; final value 32'h0000_BEFF. CSRRS MHARTID with wdata=0 -> legal; RW MHARTID -> illegal with no change.
- Trap sequence: MIE=1, then trap writes MCAUSE=2, MEPC=32'h8000_0103, MTVAL=32'h1234, MSTATUS on consecutive cycles -> ack high 4 consecutive cycles, one cycle late each. mepc_o=32'h8000_0100; mstatus reads 32'h1880; mstatus_mie_o=0. Then mret_i -> MIE=1, MPIE=1.
- Set mcycle low=32'hFFFF_FFFF via RW -> next cycle low=0, high=1. Same-cycle write to MINSTRET with instr_retire_i=1 -> written value, no +1.
- Same cycle: trap WR_MEPC data 32'h100 and RW MEPC 32'h200 -> mepc=32'h100, trap ack=1. Same cycle: trap WR_MSTATUS and mret_i -> trap result wins.
- rst_i asserted mid-trap-sequence (after MCAUSE write) -> all registers return to reset values, ack=0 the next cycle.

Source files
------------

// File: rtl/milano_pkg.sv
// Shared types for the milano core: CSR operations, CSR addresses, trap-controller
// write targets and the mstatus/mie bit layout used by the CSR file.
package milano_pkg;

    typedef enum logic [3:0] {
        CSR_OP_NONE = 4'h0,
        CSR_OP_RW   = 4'h1,
        CSR_OP_RS   = 4'h2,
        CSR_OP_RC   = 4'h3,
        CSR_OP_RWI  = 4'h5,
        CSR_OP_RSI  = 4'h6,
        CSR_OP_RCI  = 4'h7
    } csr_opt_e;

    typedef enum logic [11:0] {
        CSR_MSTATUS   = 12'h300,
        CSR_MISA      = 12'h301,
        CSR_MIE       = 12'h304,
        CSR_MTVEC     = 12'h305,
        CSR_MSCRATCH  = 12'h340,
        CSR_MEPC      = 12'h341,
        CSR_MCAUSE    = 12'h342,
        CSR_MTVAL     = 12'h343,
        CSR_MIP       = 12'h344,
        CSR_MCYCLE    = 12'hB00,
        CSR_MINSTRET  = 12'hB02,
        CSR_MCYCLEH   = 12'hB80,
        CSR_MINSTRETH = 12'hB82,
        CSR_MHARTID   = 12'hF14
    } csr_num_e;

    typedef enum logic [3:0] {
        WR_IDLE    = 4'h0,
        WR_MCAUSE  = 4'h1,
        WR_MEPC    = 4'h2,
        WR_MTVAL   = 4'h3,
        WR_MSTATUS = 4'h4
    } csr_ctrl_state_e;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_MPP_HI   = 12;
    localparam int MSTATUS_MPP_LO   = 11;

    localparam logic [31:0] MIE_MASK = 32'h0000_0888;

endpackage

// File: rtl/milano_csr_counter64.sv
// 64-bit free-running counter with independently loadable halves; a load of
// either half takes precedence over the increment in that cycle.
module milano_csr_counter64
    import milano_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inc_en_i,
    input  logic        load_lo_i,
    input  logic        load_hi_i,
    input  logic [31:0] load_data_i,
    output logic [63:0] count_o
);

    logic [63:0] count_q;
    logic [63:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_lo_i || load_hi_i) begin
            if (load_lo_i) count_d[31:0]  = load_data_i;
            if (load_hi_i) count_d[63:32] = load_data_i;
        end else if (inc_en_i) begin
            count_d = count_q + 64'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/milano_csr_file.sv
// Machine-mode CSR file: Zicsr read/modify/write port from execute, a one-write-
// per-cycle trap port with registered ack, MRET handling and the 64-bit counters.
module milano_csr_file
    import milano_pkg::*;
#(
    parameter logic [31:0] HART_ID     = 32'h0,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_1100
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        csr_en_i,
    input  logic [3:0]  csr_op_i,
    input  logic [11:0] csr_addr_i,
    input  logic [31:0] csr_wdata_i,
    output logic [31:0] csr_rdata_o,
    output logic        csr_illegal_o,
    input  logic        trap_wr_en_i,
    input  logic [3:0]  trap_wr_sel_i,
    input  logic [31:0] trap_wr_data_i,
    output logic        trap_wr_ack_o,
    input  logic        mret_i,
    input  logic        instr_retire_i,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o,
    output logic        mstatus_mie_o
);

    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic        trap_wr_ack_q;

    logic [63:0] mcycle;
    logic [63:0] minstret;

    csr_num_e        addr;
    csr_ctrl_state_e trap_sel;
    logic [31:0]     mstatus_rd;
    logic [31:0]     old_val;
    logic [31:0]     new_val;
    logic            addr_valid;
    logic            op_wr;
    logic            illegal;
    logic            csr_we;

    assign addr     = csr_num_e'(csr_addr_i);
    assign trap_sel = csr_ctrl_state_e'(trap_wr_sel_i);

    always_comb begin
        mstatus_rd = '0;
        mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        mstatus_rd[MSTATUS_MPIE_BIT] = mstatus_mpie_q;
        mstatus_rd[MSTATUS_MIE_BIT]  = mstatus_mie_q;
    end

    always_comb begin
        old_val    = '0;
        addr_valid = 1'b1;
        case (addr)
            CSR_MSTATUS:   old_val = mstatus_rd;
            CSR_MISA:      old_val = MISA_VALUE;
            CSR_MIE:       old_val = mie_q;
            CSR_MTVEC:     old_val = mtvec_q;
            CSR_MSCRATCH:  old_val = mscratch_q;
            CSR_MEPC:      old_val = mepc_q;
            CSR_MCAUSE:    old_val = mcause_q;
            CSR_MTVAL:     old_val = mtval_q;
            CSR_MIP:       old_val = '0;
            CSR_MCYCLE:    old_val = mcycle[31:0];
            CSR_MCYCLEH:   old_val = mcycle[63:32];
            CSR_MINSTRET:  old_val = minstret[31:0];
            CSR_MINSTRETH: old_val = minstret[63:32];
            CSR_MHARTID:   old_val = HART_ID;
            default:       addr_valid = 1'b0;
        endcase
    end

    // Set/clear forms with a zero operand are pure reads and never write.
    always_comb begin
        op_wr   = 1'b0;
        new_val = old_val;
        case (csr_opt_e'(csr_op_i))
            CSR_OP_RW, CSR_OP_RWI: begin
                op_wr   = 1'b1;
                new_val = csr_wdata_i;
            end
            CSR_OP_RS, CSR_OP_RSI: begin
                op_wr   = |csr_wdata_i;
                new_val = old_val | csr_wdata_i;
            end
            CSR_OP_RC, CSR_OP_RCI: begin
                op_wr   = |csr_wdata_i;
                new_val = old_val & ~csr_wdata_i;
            end
            default: ;
        endcase
    end

    assign illegal       = csr_en_i && (!addr_valid || (op_wr && addr == CSR_MHARTID));
    assign csr_we        = csr_en_i && op_wr && !illegal;
    assign csr_illegal_o = illegal;
    assign csr_rdata_o   = csr_en_i ? old_val : '0;

    // Trap writes beat MRET, which beats an instruction write to the same register.
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;

        if (trap_wr_en_i && trap_sel == WR_MSTATUS) begin
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret_i) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (csr_we && addr == CSR_MSTATUS) begin
            mstatus_mie_d  = new_val[MSTATUS_MIE_BIT];
            mstatus_mpie_d = new_val[MSTATUS_MPIE_BIT];
        end

        if (trap_wr_en_i && trap_sel == WR_MEPC) begin
            mepc_d = {trap_wr_data_i[31:2], 2'b00};
        end else if (csr_we && addr == CSR_MEPC) begin
            mepc_d = {new_val[31:2], 2'b00};
        end

        if (trap_wr_en_i && trap_sel == WR_MCAUSE) begin
            mcause_d = trap_wr_data_i;
        end else if (csr_we && addr == CSR_MCAUSE) begin
            mcause_d = new_val;
        end

        if (trap_wr_en_i && trap_sel == WR_MTVAL) begin
            mtval_d = trap_wr_data_i;
        end else if (csr_we && addr == CSR_MTVAL) begin
            mtval_d = new_val;
        end

        if (csr_we && addr == CSR_MIE)      mie_d      = new_val & MIE_MASK;
        if (csr_we && addr == CSR_MTVEC)    mtvec_d    = {new_val[31:2], 2'b00};
        if (csr_we && addr == CSR_MSCRATCH) mscratch_d = new_val;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mtvec_q        <= MTVEC_RESET;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            trap_wr_ack_q  <= 1'b0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            trap_wr_ack_q  <= trap_wr_en_i;
        end
    end

    milano_csr_counter64 u_mcycle (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .inc_en_i    (1'b1),
        .load_lo_i   (csr_we && addr == CSR_MCYCLE),
        .load_hi_i   (csr_we && addr == CSR_MCYCLEH),
        .load_data_i (new_val),
        .count_o     (mcycle)
    );

    milano_csr_counter64 u_minstret (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .inc_en_i    (instr_retire_i),
        .load_lo_i   (csr_we && addr == CSR_MINSTRET),
        .load_hi_i   (csr_we && addr == CSR_MINSTRETH),
        .load_data_i (new_val),
        .count_o     (minstret)
    );

    assign trap_wr_ack_o = trap_wr_ack_q;
    assign mtvec_o       = mtvec_q;
    assign mepc_o        = mepc_q;
    assign mstatus_mie_o = mstatus_mie_q;

endmodule
